// File: rtl/vram_scan_arbiter.sv
// rtl/vram_scan_arbiter.sv - single-port VRAM arbiter: 2x scan-out fetch, pixel writer, frame clear
module vram_scan_arbiter #(
    parameter int               H_START     = 144,
    parameter int               V_START     = 35,
    parameter int               FB_W        = 320,
    parameter int               FB_H        = 240,
    parameter int               PIX_W       = 4,
    parameter logic [PIX_W-1:0] CLEAR_VALUE = '0
) (
    input  logic             vga_clock,
    input  logic             reset,
    input  logic [9:0]       hcount,
    input  logic [9:0]       vcount,
    input  logic             hsync_in,
    input  logic             vsync_in,
    input  logic             at_display_area,
    input  logic             wr_req,
    input  logic [8:0]       wr_x,
    input  logic [7:0]       wr_y,
    input  logic [PIX_W-1:0] wr_data,
    output logic             wr_ack,
    input  logic             clear_req,
    output logic             clear_busy,
    output logic             clear_done,
    output logic [16:0]      mem_addr,
    output logic             mem_we,
    output logic [PIX_W-1:0] mem_wdata,
    input  logic [PIX_W-1:0] mem_rdata,
    output logic [PIX_W-1:0] pix_out,
    output logic             hsync_out,
    output logic             vsync_out,
    output logic             blank_out
);

    typedef enum logic {IDLE, CLEAR} state_t;

    localparam logic [16:0] LAST_ADDR = 17'(FB_W * FB_H - 1);

    state_t           state_q, state_d;
    logic [16:0]      clr_addr_q, clr_addr_d;
    logic [16:0]      addr_q, addr_d;
    logic             we_q, we_d;
    logic [PIX_W-1:0] wdata_q, wdata_d;
    logic             ack_q, ack_d;
    logic             done_q, done_d;
    logic [PIX_W-1:0] pix_q, pix_d;
    logic [1:0]       fetch_q;
    logic [2:0]       hs_q, vs_q, bl_q;

    logic [9:0]  dx, dy_half;
    logic        fetch;
    logic [16:0] fetch_addr, wr_addr;
    logic        in_range;

    // Framebuffer is shown at 2x, so only even display columns need a RAM slot.
    assign dx         = hcount - 10'(H_START);
    assign dy_half    = (vcount - 10'(V_START)) >> 1;
    assign fetch      = at_display_area && !dx[0];
    assign fetch_addr = 17'(dy_half) * 17'(FB_W) + 17'(dx >> 1);
    assign wr_addr    = 17'(wr_y) * 17'(FB_W) + 17'(wr_x);
    assign in_range   = ({1'b0, wr_x} < 10'(FB_W)) && ({1'b0, wr_y} < 9'(FB_H));

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        addr_d     = addr_q;
        we_d       = 1'b0;
        wdata_d    = wdata_q;
        ack_d      = 1'b0;
        done_d     = 1'b0;

        if (fetch) begin
            addr_d = fetch_addr;
        end else if (state_q == CLEAR) begin
            addr_d     = clr_addr_q;
            we_d       = 1'b1;
            wdata_d    = CLEAR_VALUE;
            clr_addr_d = clr_addr_q + 17'd1;
            if (clr_addr_q == LAST_ADDR) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
        end else if (wr_req && !ack_q && !clear_req) begin
            // Out-of-range requests are consumed but never reach the RAM.
            ack_d = 1'b1;
            if (in_range) begin
                addr_d  = wr_addr;
                we_d    = 1'b1;
                wdata_d = wr_data;
            end
        end

        if (state_q == IDLE && clear_req) begin
            state_d    = CLEAR;
            clr_addr_d = '0;
        end
    end

    // Pixel loads only on the stage that carries a fetch; odd columns hold it.
    always_comb begin
        pix_d = pix_q;
        if (bl_q[1]) begin
            pix_d = '0;
        end else if (fetch_q[1]) begin
            pix_d = mem_rdata;
        end
    end

    always_ff @(posedge vga_clock) begin
        if (reset) begin
            state_q    <= IDLE;
            clr_addr_q <= '0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            ack_q      <= 1'b0;
            done_q     <= 1'b0;
            pix_q      <= '0;
            fetch_q    <= '0;
            hs_q       <= '0;
            vs_q       <= '0;
            bl_q       <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            ack_q      <= ack_d;
            done_q     <= done_d;
            pix_q      <= pix_d;
            fetch_q    <= {fetch_q[0], fetch};
            hs_q       <= {hs_q[1:0], hsync_in};
            vs_q       <= {vs_q[1:0], vsync_in};
            bl_q       <= {bl_q[1:0], ~at_display_area};
        end
    end

    assign mem_addr   = addr_q;
    assign mem_we     = we_q;
    assign mem_wdata  = wdata_q;
    assign wr_ack     = ack_q;
    assign clear_busy = (state_q == CLEAR);
    assign clear_done = done_q;
    assign pix_out    = pix_q;
    assign hsync_out  = hs_q[2];
    assign vsync_out  = vs_q[2];
    assign blank_out  = bl_q[2];

endmodule

// File: tb/tb_vram_scan_arbiter.sv
// tb/tb_vram_scan_arbiter.sv - bench for vram_scan_arbiter with RAM and reference model
module tb_vram_scan_arbiter;

    localparam int FB_W = 320;
    localparam int FB_H = 240;
    localparam int NPIX = FB_W * FB_H;
    localparam int H0   = 144;
    localparam int V0   = 35;

    logic       vga_clock = 1'b0;
    logic       reset = 1'b1;
    logic [9:0] hcount = '0, vcount = '0;
    logic       hsync_in = 1'b0, vsync_in = 1'b0, at_display_area = 1'b0;
    logic       wr_req = 1'b0;
    logic [8:0] wr_x = '0;
    logic [7:0] wr_y = '0;
    logic [3:0] wr_data = '0;
    logic       wr_ack, clear_req = 1'b0, clear_busy, clear_done;
    logic [16:0] mem_addr;
    logic       mem_we;
    logic [3:0] mem_wdata, mem_rdata, pix_out;
    logic       hsync_out, vsync_out, blank_out;

    vram_scan_arbiter dut (
        .vga_clock(vga_clock), .reset(reset), .hcount(hcount), .vcount(vcount),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .at_display_area(at_display_area),
        .wr_req(wr_req), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data), .wr_ack(wr_ack),
        .clear_req(clear_req), .clear_busy(clear_busy), .clear_done(clear_done),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .pix_out(pix_out), .hsync_out(hsync_out), .vsync_out(vsync_out), .blank_out(blank_out)
    );

    always #5 vga_clock = ~vga_clock;

    // Synchronous-read single-port RAM with a bench-side preload port
    bit [3:0]    ram [0:131071];
    logic [3:0]  ram_q;
    logic        pl_we = 1'b0;
    logic [16:0] pl_addr = '0;
    logic [3:0]  pl_val = '0;
    always @(posedge vga_clock) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        else if (pl_we) ram[pl_addr] <= pl_val;
        ram_q <= ram[mem_addr];
    end
    assign mem_rdata = ram_q;

    typedef struct { int pix; bit hs; bit vs; bit bl; } pipe_t;
    typedef struct { int x; int y; int d; } wr_t;

    int checks = 0, passes = 0;
    bit [3:0] shadow [0:131071];
    int m_addr = 0, m_wdata = 0, m_caddr = 0, m_pix = 0;
    bit m_we = 0, m_ack = 0, m_busy = 0, m_done = 0, m_hs = 0, m_vs = 0, m_bl = 0;
    pipe_t pq[$];
    wr_t   wq[$];
    int nwrites = 0, ndone = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) passes++;
        else $error("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    // Expected effect of the inputs currently applied, seen after the next edge.
    task automatic predict();
        int dx, dy;
        bit fetch, was_busy, ack_prev;
        pipe_t e;
        if (reset) begin
            m_addr = 0; m_we = 0; m_wdata = 0; m_ack = 0; m_busy = 0; m_caddr = 0;
            m_done = 0; m_pix = 0; m_hs = 0; m_vs = 0; m_bl = 0;
            pq.delete();
            e = '{0, 0, 0, 0};
            pq.push_back(e);
            pq.push_back(e);
            return;
        end
        dx = int'(hcount) - H0;
        dy = int'(vcount) - V0;
        fetch = at_display_area && (dx % 2 == 0);
        was_busy = m_busy;
        ack_prev = m_ack;
        m_we = 0; m_ack = 0; m_done = 0;
        e.hs = hsync_in; e.vs = vsync_in; e.bl = !at_display_area;
        e.pix = at_display_area ? -1 : 0;
        if (fetch) begin
            m_addr = (dy / 2) * FB_W + dx / 2;
            e.pix = int'(shadow[m_addr]);
        end else if (was_busy) begin
            m_we = 1; m_addr = m_caddr; m_wdata = 0; shadow[m_caddr] = 4'h0;
            if (m_caddr == NPIX - 1) begin
                m_busy = 0; m_done = 1;
            end
            m_caddr++;
        end else if (wr_req && !ack_prev && !clear_req) begin
            m_ack = 1;
            if (int'(wr_x) < FB_W && int'(wr_y) < FB_H) begin
                m_we = 1; m_addr = int'(wr_y) * FB_W + int'(wr_x);
                m_wdata = int'(wr_data); shadow[m_addr] = wr_data;
            end
        end
        if (!was_busy && clear_req) begin
            m_busy = 1; m_caddr = 0;
        end
        pq.push_back(e);
    endtask

    task automatic compare();
        pipe_t e;
        chk("mem_addr", 32'(mem_addr), m_addr);
        chk("mem_we", 32'(mem_we), 32'(m_we));
        if (m_we) chk("mem_wdata", 32'(mem_wdata), m_wdata);
        chk("wr_ack", 32'(wr_ack), 32'(m_ack));
        chk("clear_busy", 32'(clear_busy), 32'(m_busy));
        chk("clear_done", 32'(clear_done), 32'(m_done));
        if (pq.size() == 3) begin
            e = pq.pop_front();
            if (e.pix >= 0) m_pix = e.pix;
            m_hs = e.hs; m_vs = e.vs; m_bl = e.bl;
        end
        chk("pix_out", 32'(pix_out), m_pix);
        chk("hsync_out", 32'(hsync_out), 32'(m_hs));
        chk("vsync_out", 32'(vsync_out), 32'(m_vs));
        chk("blank_out", 32'(blank_out), 32'(m_bl));
    endtask

    task automatic drive_writer();
        if (wq.size() > 0) begin
            wr_req = 1'b1;
            wr_x = 9'(wq[0].x);
            wr_y = 8'(wq[0].y);
            wr_data = 4'(wq[0].d);
        end else begin
            wr_req = 1'b0;
        end
    endtask

    task automatic push_wr(input int x, input int y, input int d);
        wr_t w;
        w.x = x; w.y = y; w.d = d;
        wq.push_back(w);
        drive_writer();
    endtask

    task automatic step();
        predict();
        @(posedge vga_clock);
        #1;
        compare();
        if (mem_we) nwrites++;
        if (clear_done) ndone++;
        if (wr_ack && wq.size() > 0) wq.delete(0);
        drive_writer();
    endtask

    task automatic set_scan(input bit ad, input int h, input int v);
        at_display_area = ad;
        hcount = 10'(h);
        vcount = 10'(v);
    endtask

    initial begin
        int ack_cnt;
        int ack_at [4];
        int ack_adr [4];

        // Reset with a preload of address 321
        pl_we = 1'b1; pl_addr = 17'd321; pl_val = 4'hA;
        shadow[321] = 4'hA;
        step();
        pl_we = 1'b0;
        step();
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_mem_wdata", 32'(mem_wdata), 0);
        chk("rst_pix", 32'(pix_out), 0);
        reset = 1'b0;

        // Scan-out addressing and latency
        set_scan(1, 144, 35); hsync_in = 1'b1;
        step();
        hsync_in = 1'b0;
        chk("scan_addr0", 32'(mem_addr), 0);
        chk("scan_we0", 32'(mem_we), 0);
        set_scan(1, 146, 37);
        step();
        chk("scan_addr321", 32'(mem_addr), 321);
        set_scan(1, 147, 37); step();
        set_scan(1, 148, 37); step();
        chk("scan_pix_t3", 32'(pix_out), 32'hA);
        set_scan(1, 149, 37); step();
        chk("scan_pix_t4", 32'(pix_out), 32'hA);
        set_scan(0, 700, 37);
        for (int i = 0; i < 3; i++) step();
        chk("scan_blank", 32'(blank_out), 1);
        chk("scan_blank_pix", 32'(pix_out), 0);

        // Write on an odd-dx cycle, then on an even-dx cycle
        set_scan(1, 145, 35);
        push_wr(5, 7, 3);
        step();
        chk("wr_odd_ack", 32'(wr_ack), 1);
        chk("wr_odd_we", 32'(mem_we), 1);
        chk("wr_odd_addr", 32'(mem_addr), 2245);
        chk("wr_odd_data", 32'(mem_wdata), 3);
        set_scan(1, 146, 35); step();
        push_wr(5, 7, 3);
        step();
        chk("wr_even_noack", 32'(wr_ack), 0);
        set_scan(1, 147, 35); step();
        chk("wr_even_ack_late", 32'(wr_ack), 1);

        // Back-to-back writes during vblank
        set_scan(0, 0, 500);
        step();
        for (int i = 0; i < 4; i++) push_wr(10 + i, 0, i + 1);
        ack_cnt = 0;
        for (int s = 0; s < 8; s++) begin
            step();
            if (wr_ack && ack_cnt < 4) begin
                ack_at[ack_cnt] = s;
                ack_adr[ack_cnt] = int'(mem_addr);
                ack_cnt++;
            end
        end
        chk("b2b_count", ack_cnt, 4);
        for (int i = 0; i < 4 && i < ack_cnt; i++) begin
            chk("b2b_cycle", ack_at[i], 2 * i);
            chk("b2b_addr", ack_adr[i], 10 + i);
        end

        // Out-of-range write is acked but dropped
        push_wr(320, 0, 5);
        step();
        chk("oor_ack", 32'(wr_ack), 1);
        chk("oor_we", 32'(mem_we), 0);

        // Full clear with a simultaneous write and occasional fetch cycles
        step();
        push_wr(1, 1, 7);
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        chk("clr_start_busy", 32'(clear_busy), 1);
        chk("clr_start_noack", 32'(wr_ack), 0);
        nwrites = 0; ndone = 0;
        for (int cyc = 0; cyc < 90000 && clear_busy; cyc++) begin
            if (cyc % 37 == 0) set_scan(1, 144 + 2 * (cyc % 300), 35 + (cyc % 480));
            else set_scan(0, 0, 500);
            if (cyc == 500) push_wr(2, 2, 9);
            if (cyc == 1000) clear_req = 1'b1;
            else clear_req = 1'b0;
            step();
        end
        clear_req = 1'b0;
        set_scan(0, 0, 500);
        chk("clr_finished", 32'(clear_busy), 0);
        chk("clr_writes", nwrites, NPIX);
        chk("clr_done_once", ndone, 1);
        for (int s = 0; s < 10 && wq.size() > 0; s++) step();
        chk("clr_pending_acked", wq.size(), 0);

        // Reset mid-clear at clear address 1000
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        nwrites = 0;
        for (int s = 0; s < 2000 && nwrites < 1000; s++) step();
        chk("rmc_reached", nwrites, 1000);
        reset = 1'b1;
        step();
        chk("rmc_busy", 32'(clear_busy), 0);
        chk("rmc_addr", 32'(mem_addr), 0);
        chk("rmc_we", 32'(mem_we), 0);
        chk("rmc_wdata", 32'(mem_wdata), 0);
        chk("rmc_pix", 32'(pix_out), 0);
        chk("rmc_blank", 32'(blank_out), 0);
        reset = 1'b0;
        nwrites = 0;
        for (int s = 0; s < 50; s++) step();
        chk("rmc_no_writes", nwrites, 0);

        // Randomized traffic over a small framebuffer window
        for (int s = 0; s < 3000; s++) begin
            if ($urandom_range(1, 0) == 1)
                set_scan(1, H0 + int'($urandom_range(79, 0)), V0 + int'($urandom_range(7, 0)));
            else
                set_scan(0, int'($urandom_range(799, 0)), int'($urandom_range(524, 0)));
            hsync_in = 1'($urandom_range(1, 0));
            vsync_in = 1'($urandom_range(1, 0));
            if (wq.size() < 2 && $urandom_range(3, 0) == 0) begin
                if ($urandom_range(7, 0) == 0)
                    push_wr(320 + int'($urandom_range(19, 0)), int'($urandom_range(3, 0)), int'($urandom_range(15, 0)));
                else if ($urandom_range(7, 0) == 0)
                    push_wr(int'($urandom_range(39, 0)), 240 + int'($urandom_range(10, 0)), int'($urandom_range(15, 0)));
                else
                    push_wr(int'($urandom_range(39, 0)), int'($urandom_range(3, 0)), int'($urandom_range(15, 0)));
            end
            step();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
